// File: rtl/modport_top.sv
// Pointwise (1x1) convolution engine: host-loaded feature memory and weight
// cache, one MAC per cycle, results streamed with coordinates.
// Optional build macro MODPORT_TOP_SATURATE_EN: saturate results instead of wrapping.
module modport_top #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 8,
  parameter int FEATURE_MAP_HEIGHT = 8,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 4,
  parameter int OUTPUT_SHIFT       = 4,
  localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CHW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         int_mem_we,
  input  logic                         overlap_cache_we,
  input  logic                         b_zero,
  input  logic                         data_ready,
  output logic                         fsm_done,
  input  logic [DATA_WIDTH-1:0]        a_input,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic signed [DATA_WIDTH-1:0] b_input,
  input  logic                         b_valid,
  output logic                         b_ready,
  output logic signed [DATA_WIDTH-1:0] output_data,
  output logic                         output_valid,
  output logic [XW-1:0]                output_x,
  output logic [YW-1:0]                output_y,
  output logic [CHW-1:0]               output_ch,
  input  logic                         start,
  output logic                         running,
  output logic [1:0]                   dbg_state_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int FD  = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * INPUT_NB_CHANNELS;
  localparam int WD  = OUTPUT_NB_CHANNELS * INPUT_NB_CHANNELS;
  localparam int FAW = (FD > 1) ? $clog2(FD) : 1;
  localparam int WAW = (WD > 1) ? $clog2(WD) : 1;
  localparam int CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int PW  = 2 * DW;
  localparam int AW  = 2 * DW + $clog2(INPUT_NB_CHANNELS) + 1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t state_q, state_d;
  logic [CIW-1:0] ci_q, ci_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic signed [DW-1:0] data_q, data_d;
  logic [XW-1:0]  ox_q, ox_d;
  logic [YW-1:0]  oy_q, oy_d;
  logic [CHW-1:0] och_q, och_d;

  logic signed [DW-1:0] feat_mem [FD];
  logic signed [DW-1:0] wt_mem [WD];

  // Handshake: a write commits on a cycle where a_valid & a_ready & b_valid &
  // b_ready are all high; both readies are high only while the engine is idle.
  logic wr_fire, feat_in_range, wt_in_range;
  logic signed [DW-1:0] wr_data;

  assign running     = (state_q == MAC) || (state_q == EMIT);
  assign a_ready     = !running;
  assign b_ready     = !running;
  assign fsm_done    = (state_q == DONE);
  assign dbg_state_o = state_q;

  assign wr_fire       = a_valid && a_ready && b_valid && b_ready;
  assign feat_in_range = a_input < DW'(FD);
  assign wt_in_range   = a_input < DW'(WD);
  assign wr_data       = b_zero ? '0 : b_input;

  // Memory contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_fire && int_mem_we && feat_in_range) feat_mem[a_input[FAW-1:0]] <= wr_data;
    if (wr_fire && overlap_cache_we && wt_in_range) wt_mem[a_input[WAW-1:0]] <= wr_data;
  end

  logic [FAW-1:0] feat_raddr;
  logic [WAW-1:0] wt_raddr;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] result;

  assign feat_raddr = FAW'((int'(y_q) * FEATURE_MAP_WIDTH + int'(x_q)) * INPUT_NB_CHANNELS
                           + int'(ci_q));
  assign wt_raddr   = WAW'(int'(ch_q) * INPUT_NB_CHANNELS + int'(ci_q));
  assign prod       = PW'(feat_mem[feat_raddr]) * PW'(wt_mem[wt_raddr]);
  assign sum        = acc_q + AW'(prod);

`ifdef MODPORT_TOP_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [AW-1:0] shifted;
  assign shifted = sum >>> OUTPUT_SHIFT;
  always_comb begin
    result = shifted[DW-1:0];
    if (shifted > MAXV)      result = MAXV[DW-1:0];
    else if (shifted < MINV) result = MINV[DW-1:0];
  end
`else
  assign result = DW'(sum >>> OUTPUT_SHIFT);
`endif

  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    x_d     = x_q;
    y_d     = y_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    och_d   = och_q;
    case (state_q)
      IDLE: begin
        if (start && data_ready) begin
          state_d = MAC;
          ci_d    = '0;
          x_d     = '0;
          y_d     = '0;
          ch_d    = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        acc_d = sum;
        if (ci_q == CIW'(INPUT_NB_CHANNELS - 1)) begin
          // Result is registered on the last MAC edge so it is visible during EMIT.
          ci_d    = '0;
          state_d = EMIT;
          valid_d = 1'b1;
          data_d  = result;
          ox_d    = x_q;
          oy_d    = y_q;
          och_d   = ch_q;
        end else begin
          ci_d = ci_q + CIW'(1);
        end
      end
      EMIT: begin
        acc_d   = '0;
        state_d = MAC;
        if (ch_q == CHW'(OUTPUT_NB_CHANNELS - 1)) begin
          ch_d = '0;
          if (x_q == XW'(FEATURE_MAP_WIDTH - 1)) begin
            x_d = '0;
            if (y_q == YW'(FEATURE_MAP_HEIGHT - 1)) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          ch_d = ch_q + CHW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ci_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      och_q   <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      och_q   <= och_d;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = data_q;
  assign output_x     = ox_q;
  assign output_y     = oy_q;
  assign output_ch    = och_q;

endmodule

// File: tb/tb_modport_top.sv
// Bench for modport_top: uniform-data vector table, random data against a
// reference model, zero writes, write/start lockout and mid-run reset.
module tb_modport_top;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int CIN   = 2;
  localparam int COUT  = 4;
  localparam int SHIFT = 4;
  localparam int FD    = W * H * CIN;
  localparam int WD    = COUT * CIN;
  localparam int NOUT  = W * H * COUT;
  localparam int RUN_CYCLES = NOUT * (CIN + 1) + 1;
`ifdef MODPORT_TOP_SATURATE_EN
  localparam logic [15:0] EXP_MAXSQ = 16'h7FFF;
  localparam logic [15:0] EXP_MINMX = 16'h8000;
`else
  localparam logic [15:0] EXP_MAXSQ = 16'hE000;
  localparam logic [15:0] EXP_MINMX = 16'h1000;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic int_mem_we = 1'b0, overlap_cache_we = 1'b0, b_zero = 1'b0, data_ready = 1'b0;
  logic fsm_done, a_ready, b_ready, output_valid, running;
  logic [15:0] a_input = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, start = 1'b0;
  logic signed [15:0] b_input = '0;
  logic signed [15:0] output_data;
  logic [2:0] output_x, output_y;
  logic [1:0] output_ch, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic signed [15:0] feat_m [FD];
  logic signed [15:0] wt_m [WD];

  typedef struct {
    logic [15:0] feat;
    logic [15:0] wt;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[4];

  modport_top dut (
    .clk(clk), .arst_n(arst_n), .int_mem_we(int_mem_we),
    .overlap_cache_we(overlap_cache_we), .b_zero(b_zero), .data_ready(data_ready),
    .fsm_done(fsm_done), .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
    .output_data(output_data), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .start(start), .running(running), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(int x, int y, int ch);
    longint acc = 0;
    for (int ci = 0; ci < CIN; ci++)
      acc += longint'(feat_m[(y * W + x) * CIN + ci]) * longint'(wt_m[ch * CIN + ci]);
    acc = acc >>> SHIFT;
`ifdef MODPORT_TOP_SATURATE_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  // driver tasks
  task automatic write_word(bit fe, bit we, int addr, logic [15:0] d, bit z);
    @(negedge clk);
    int_mem_we = fe; overlap_cache_we = we; b_zero = z;
    a_input = 16'(addr); b_input = d; a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0; int_mem_we = 1'b0; overlap_cache_we = 1'b0; b_zero = 1'b0;
    if (fe && addr < FD) feat_m[addr] = z ? 16'sd0 : d;
    if (we && addr < WD) wt_m[addr] = z ? 16'sd0 : d;
  endtask

  task automatic load_uniform(logic [15:0] f, logic [15:0] w);
    for (int a = 0; a < FD; a++) write_word(1'b1, 1'b0, a, f, 1'b0);
    for (int a = 0; a < WD; a++) write_word(1'b0, 1'b1, a, w, 1'b0);
  endtask

  task automatic run_check(string name, bit use_const, logic [15:0] cexp,
                           bit disturb, int abort_after);
    int k = 0, nout = 0, ndone = 0, done_cyc = 0;
    bit fin = 0;
    logic [23:0] e;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ch = 0; ch < COUT; ch++)
          exp_q.push_back({3'(x), 3'(y), 2'(ch), use_const ? cexp : model(x, y, ch)});
    @(negedge clk);
    data_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && k < 2 * RUN_CYCLES) begin
      @(negedge clk);
      k++;
      if (k == 1) check({name, " running_after_start"}, running, 1);
      if (output_valid) begin
        nout++;
        if (exp_q.size() == 0) check({name, " unexpected_output"}, nout, 0);
        else begin
          e = exp_q.pop_front();
          check({name, " out"}, {output_x, output_y, output_ch, output_data}, e);
        end
      end
      if (fsm_done) begin
        ndone++; done_cyc = k; fin = 1;
        check({name, " running_at_done"}, running, 0);
        check({name, " a_ready_at_done"}, a_ready, 1);
      end
      if (disturb && k == 50) begin
        check({name, " a_ready_busy"}, {a_ready, b_ready}, 2'b00);
        a_valid = 1'b1; b_valid = 1'b1; int_mem_we = 1'b1; overlap_cache_we = 1'b1;
        a_input = 16'd0; b_input = 16'h1234; start = 1'b1;
      end
      if (disturb && k == 51) begin
        a_valid = 1'b0; b_valid = 1'b0; int_mem_we = 1'b0; overlap_cache_we = 1'b0;
        start = 1'b0;
      end
      if (abort_after > 0 && nout == abort_after) begin
        arst_n = 1'b0;
        #1;
        check({name, " abort_running"}, running, 0);
        check({name, " abort_valid"}, output_valid, 0);
        check({name, " abort_ready"}, a_ready, 1);
        check({name, " abort_state"}, dbg_state, 0);
        @(negedge clk);
        check({name, " abort_no_done"}, fsm_done, 0);
        arst_n = 1'b1;
        exp_q.delete();
        return;
      end
    end
    check({name, " done_seen"}, ndone, 1);
    check({name, " done_cycle"}, done_cyc, RUN_CYCLES);
    check({name, " n_outputs"}, nout, NOUT);
    check({name, " queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, " done_one_cycle"}, fsm_done, 0);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'h0010, 16'h0020};
    vecs[1] = '{16'h7FFF, 16'h7FFF, EXP_MAXSQ};
    vecs[2] = '{16'hFFFD, 16'h0005, 16'hFFFE};
    vecs[3] = '{16'h8000, 16'h7FFF, EXP_MINMX};

    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("reset running", running, 0);
    check("reset done", fsm_done, 0);
    check("reset valid", output_valid, 0);
    check("reset outputs", {output_data, output_x, output_y, output_ch}, 0);
    check("reset ready", {a_ready, b_ready}, 2'b11);
    check("reset state", dbg_state, 0);

    data_ready = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_no_data_ready running", running, 0);

    for (int i = 0; i < 4; i++) begin
      load_uniform(vecs[i].feat, vecs[i].wt);
      run_check($sformatf("vec%0d", i), 1'b1, vecs[i].exp, 1'b0, 0);
    end

    load_uniform(16'h0001, 16'h0000);
    write_word(1'b0, 1'b1, 0, 16'h0005, 1'b1);
    write_word(1'b0, 1'b1, 1, 16'h0100, 1'b1);
    run_check("zero_write", 1'b1, 16'h0000, 1'b0, 0);

    for (int a = 0; a < FD; a++) write_word(1'b1, 1'b0, a, 16'($urandom_range(0, 65535)), 1'b0);
    for (int a = 0; a < WD; a++) write_word(1'b0, 1'b1, a, 16'($urandom_range(0, 65535)), 1'b0);
    write_word(1'b1, 1'b1, 3, 16'h0321, 1'b0);
    write_word(1'b1, 1'b1, FD + 5, 16'h7777, 1'b0);
    write_word(1'b0, 1'b1, WD + 2, 16'h5555, 1'b0);
    run_check("random_busy", 1'b0, 16'h0, 1'b1, 0);
    run_check("random_rerun", 1'b0, 16'h0, 1'b0, 0);
    run_check("abort", 1'b0, 16'h0, 1'b0, 10);
    run_check("after_abort", 1'b0, 16'h0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
